parallel_operand_loader: RTL and testbench

- Upstream feeder for the parallel 4-lane vector unit.
- Collects a serial byte stream, 24 bytes per frame, into six 4-lane operand vectors a..f through a valid/ready handshake.
- Stages each frame in a shadow buffer, then presents it atomically on registered outputs a1..f4 with an out_valid/out_ready handshake.
- Output operands stay stable while the next frame loads.

---
 rtl/parallel_operand_loader.sv | 111 +++++++++++
 tb/tb_parallel_operand_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/parallel_operand_loader.sv
// Collects a 24-byte serial frame into a staging buffer, then hands it to
// registered 4-lane operand vectors a..f with an out_valid/out_ready handshake.
module parallel_operand_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    output logic [WIDTH-1:0] a1, a2, a3, a4,
    output logic [WIDTH-1:0] b1, b2, b3, b4,
    output logic [WIDTH-1:0] c1, c2, c3, c4,
    output logic [WIDTH-1:0] d1, d2, d3, d4,
    output logic [WIDTH-1:0] e1, e2, e3, e4,
    output logic [WIDTH-1:0] f1, f2, f3, f4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic [7:0]       err_count
);
    localparam int NBYTES = 24;

    logic [4:0]       idx_reg;
    logic             stage_full_reg;
    logic             out_valid_reg;
    logic             frame_err_reg;
    logic [7:0]       err_count_reg;
    logic [WIDTH-1:0] stage_mem [NBYTES];
    logic [WIDTH-1:0] lane_reg  [NBYTES];

    logic accept;
    logic at_end;
    logic frame_ok;
    logic frame_bad;
    logic transfer;

    always_comb begin
        accept    = in_valid && !stage_full_reg;
        at_end    = (idx_reg == 5'(NBYTES - 1));
        frame_ok  = accept && in_last && at_end;
        // A frame is malformed when in_last and the final index disagree.
        frame_bad = accept && (in_last != at_end);
        transfer  = stage_full_reg && (!out_valid_reg || out_ready);
    end

    // Staging buffer needs no reset: stage_full gates every read of it.
    always_ff @(posedge clk) begin
        if (accept) begin
            stage_mem[idx_reg] <= in_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg[gi] <= '0;
                end else if (transfer) begin
                    lane_reg[gi] <= stage_mem[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg        <= '0;
            stage_full_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            frame_err_reg  <= 1'b0;
            err_count_reg  <= '0;
        end else begin
            if (accept) begin
                idx_reg <= (in_last || at_end) ? 5'd0 : idx_reg + 5'd1;
            end

            // Accept and transfer are exclusive since accept needs !stage_full.
            if (frame_ok) begin
                stage_full_reg <= 1'b1;
            end else if (transfer) begin
                stage_full_reg <= 1'b0;
            end

            if (transfer) begin
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end

            frame_err_reg <= frame_bad;
            if (frame_bad && err_count_reg != 8'hFF) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

    assign in_ready  = !stage_full_reg;
    assign out_valid = out_valid_reg;
    assign frame_err = frame_err_reg;
    assign err_count = err_count_reg;

    assign a1 = lane_reg[0];  assign a2 = lane_reg[1];  assign a3 = lane_reg[2];  assign a4 = lane_reg[3];
    assign b1 = lane_reg[4];  assign b2 = lane_reg[5];  assign b3 = lane_reg[6];  assign b4 = lane_reg[7];
    assign c1 = lane_reg[8];  assign c2 = lane_reg[9];  assign c3 = lane_reg[10]; assign c4 = lane_reg[11];
    assign d1 = lane_reg[12]; assign d2 = lane_reg[13]; assign d3 = lane_reg[14]; assign d4 = lane_reg[15];
    assign e1 = lane_reg[16]; assign e2 = lane_reg[17]; assign e3 = lane_reg[18]; assign e4 = lane_reg[19];
    assign f1 = lane_reg[20]; assign f2 = lane_reg[21]; assign f3 = lane_reg[22]; assign f4 = lane_reg[23];

endmodule

// File: tb/tb_parallel_operand_loader.sv
// Scoreboard bench for parallel_operand_loader: the driver queues expected
// frames and error counts, a negedge monitor checks them as the DUT emits them.
module tb_parallel_operand_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;
    logic [7:0] a1, a2, a3, a4, b1, b2, b3, b4, c1, c2, c3, c4;
    logic [7:0] d1, d2, d3, d4, e1, e2, e3, e4, f1, f2, f3, f4;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic [7:0] err_count;

    parallel_operand_loader #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .b1(b1), .b2(b2), .b3(b3), .b4(b4),
        .c1(c1), .c2(c2), .c3(c3), .c4(c4), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .e1(e1), .e2(e2), .e3(e3), .e4(e4), .f1(f1), .f2(f2), .f3(f3), .f4(f4),
        .out_valid(out_valid), .out_ready(out_ready),
        .frame_err(frame_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    wire [191:0] lanes = {a1, a2, a3, a4, b1, b2, b3, b4, c1, c2, c3, c4,
                          d1, d2, d3, d4, e1, e2, e3, e4, f1, f2, f3, f4};

    // Frames are written a1 first (MSB) through f4 (LSB).
    localparam logic [191:0] FR1 = {
        8'd2, 8'd4, 8'd6, 8'd8,  8'd1, 8'd2, 8'd3, 8'd4,  8'd3, 8'd5, 8'd7, 8'd9,
        8'd2, 8'd4, 8'd6, 8'd8,  8'd1, 8'd3, 8'd5, 8'd7,  8'd2, 8'd4, 8'd6, 8'd8};
    localparam logic [191:0] FR2 = {
        8'd3, 8'd5, 8'd7, 8'd9,  8'd2, 8'd1, 8'd2, 8'd3,  8'd4, 8'd6, 8'd8, 8'd8,
        8'd1, 8'd3, 8'd5, 8'd7,  8'd2, 8'd4, 8'd6, 8'd8,  8'd2, 8'd3, 8'd5, 8'd7};

    logic [191:0] fr3, fr4;
    logic [191:0] exp_q [$];
    logic [7:0]   err_q [$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is accepted.
    task automatic send_byte(input logic [7:0] d, input logic last);
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        for (int t = 0; t < 500; t++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        $display("FAIL send_byte: in_ready stuck low, got 0 want 1");
        $fatal(1, "driver timeout");
    endtask

    task automatic send_frame(input logic [191:0] fr, input int n, input logic last_flag, input bit gap);
        for (int i = 0; i < n; i++) begin
            send_byte(fr[(23 - i) * 8 +: 8], (i == n - 1) ? last_flag : 1'b0);
            if (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: compares frames on each output handshake, error counts on each
    // frame_err pulse, and lane stability while the consumer stalls.
    logic [191:0] prev_lanes;
    bit           prev_hold = 1'b0;
    bit           prev_err  = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_lanes", lanes, prev_lanes);
                check("hold_valid", {191'd0, out_valid}, 192'd1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL frame_out: got unexpected frame %h want none", lanes);
                end else begin
                    check("frame_out", lanes, exp_q.pop_front());
                end
            end
            if (frame_err) begin
                if (prev_err) begin
                    n_cmp++; n_fail++;
                    $display("FAIL err_pulse: got 2+ cycles want 1");
                end
                if (err_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL err_event: got unexpected frame_err want none");
                end else begin
                    check("err_count", {184'd0, err_count}, {184'd0, err_q.pop_front()});
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_lanes = lanes;
            prev_err   = frame_err;
        end
    end

    initial begin
        for (int i = 0; i < 24; i++) begin
            fr3[(23 - i) * 8 +: 8] = 8'h10 + 8'(i);
            fr4[(23 - i) * 8 +: 8] = 8'h60 + 8'(i);
        end
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        check("rst_in_ready", {191'd0, in_ready}, 192'd1);
        check("rst_out_valid", {191'd0, out_valid}, 192'd0);
        check("rst_lanes", lanes, 192'd0);
        check("rst_err", {183'd0, frame_err, err_count}, 192'd0);

        // Basic frame with out_ready high.
        exp_q.push_back(FR1);
        send_frame(FR1, 24, 1'b1, 1'b0);
        check("s1_in_ready_low", {190'd0, in_ready, out_valid}, 192'd0);
        idle(1);
        check("s1_valid_up", {190'd0, in_ready, out_valid}, 192'd3);
        idle(1);
        check("s1_valid_down", {191'd0, out_valid}, 192'd0);

        // Backpressure: two frames pile up behind a stalled consumer.
        out_ready = 1'b0;
        exp_q.push_back(FR1);
        exp_q.push_back(FR2);
        send_frame(FR1, 24, 1'b1, 1'b0);
        send_frame(FR2, 24, 1'b1, 1'b0);
        idle(3);
        check("bp_in_ready", {190'd0, in_ready, out_valid}, 192'd1);
        check("bp_lanes_f1", lanes, FR1);
        out_ready = 1'b1;
        idle(1);
        check("bp_swap_valid", {191'd0, out_valid}, 192'd1);
        check("bp_swap_lanes", lanes, FR2);
        idle(1);
        check("bp_drained", {190'd0, in_ready, out_valid}, 192'd2);

        // Early in_last on byte 11.
        err_q.push_back(8'd1);
        send_frame(FR1, 11, 1'b1, 1'b0);
        check("e1_pulse", {183'd0, frame_err, err_count}, {183'd0, 1'b1, 8'd1});
        idle(1);
        check("e1_pulse_end", {191'd0, frame_err}, 192'd0);
        check("e1_lanes_kept", lanes, FR2);
        check("e1_no_valid", {191'd0, out_valid}, 192'd0);
        exp_q.push_back(fr3);
        send_frame(fr3, 24, 1'b1, 1'b0);
        idle(3);

        // Missing in_last on byte 24.
        err_q.push_back(8'd2);
        send_frame(fr4, 24, 1'b0, 1'b0);
        check("e2_pulse", {183'd0, frame_err, err_count}, {183'd0, 1'b1, 8'd2});
        idle(3);
        check("e2_no_valid", {191'd0, out_valid}, 192'd0);
        check("e2_lanes_kept", lanes, fr3);

        // Gapped input.
        exp_q.push_back(FR1);
        send_frame(FR1, 24, 1'b1, 1'b1);
        idle(3);

        // Reset mid-frame with a frame presented.
        out_ready = 1'b0;
        send_frame(FR2, 24, 1'b1, 1'b0);
        send_frame(fr3, 12, 1'b0, 1'b0);
        check("r_presented", lanes, FR2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("r_out_valid", {191'd0, out_valid}, 192'd0);
        check("r_lanes", lanes, 192'd0);
        check("r_in_ready", {183'd0, in_ready, err_count}, {183'd0, 1'b1, 8'd0});
        out_ready = 1'b1;
        exp_q.push_back(fr4);
        send_frame(fr4, 24, 1'b1, 1'b0);

        for (int t = 0; t < 100 && (exp_q.size() != 0 || err_q.size() != 0); t++) begin
            idle(1);
        end
        check("drain_frames", 192'(exp_q.size()), 192'd0);
        check("drain_errs", 192'(err_q.size()), 192'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
